// File: rtl/rv_ctrl_pkg.sv
// Shared types and instruction encodings for the core run controller.
// STEP_DEBUG_EN adds the PAUSE state used for single-step debugging.
package rv_ctrl_pkg;

  localparam logic [31:0] ECALL_INSN  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
`ifdef STEP_DEBUG_EN
    ST_PAUSE,
`endif
    ST_HALT
  } run_state_e;

  function automatic logic is_halt_insn(input logic [31:0] insn);
    return (insn == ECALL_INSN) || (insn == EBREAK_INSN);
  endfunction

endpackage

// File: rtl/imem_load_counter.sv
// Saturating instruction-memory word index with a sticky overflow flag.
// The last slot is written once; every later beat is accepted but dropped.
module imem_load_counter #(
  parameter int IMEM_SIZE = 128,
  parameter int AW        = $clog2(IMEM_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          xfer,
  input  logic          clear,
  output logic [AW-1:0] idx,
  output logic          we,
  output logic          ovf
);

  localparam logic [AW-1:0] LAST_IDX = AW'(IMEM_SIZE - 1);

  logic [AW-1:0] idx_q, idx_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;

  // full_q marks that the last slot has already been written, since the
  // index alone cannot tell "at last slot" from "past last slot".
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    idx_d  = idx_q;
    full_d = full_q;
    ovf_d  = ovf_q;
    if (xfer) begin
      if (full_q)                ovf_d  = 1'b1;
      else if (idx_q == LAST_IDX) full_d = 1'b1;
      else                       idx_d  = idx_q + AW'(1);
      if (clear) begin
        idx_d  = '0;
        full_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  assign idx = idx_q;
  assign we  = xfer && !full_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/core_run_controller.sv
// Loads a program into instruction memory, then runs the core until ECALL/EBREAK.
// Define STEP_DEBUG_EN to add pause/step inputs and the PAUSE state.
module core_run_controller
  import rv_ctrl_pkg::*;
#(
  parameter int IMEM_SIZE = 128,
  parameter int AW        = $clog2(IMEM_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic          start,
`ifdef STEP_DEBUG_EN
  input  logic          pause,
  input  logic          step,
`endif
  input  logic [31:0]   instruction,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_rst,
  output logic          core_en,
  output logic          halted,
  output logic          load_ovf,
  output logic [31:0]   cycle_count
);

  run_state_e  state_q, state_d;
  logic [31:0] cycle_count_q, cycle_count_d;
  logic        halt_insn;
  logic        xfer;
  logic        load_done;

  assign halt_insn = is_halt_insn(instruction);

  // Reset gates the handshake so no stray write can occur while it is held.
  assign xfer      = load_valid && load_ready && !reset;
  assign load_done = xfer && load_last;

  imem_load_counter #(
    .IMEM_SIZE(IMEM_SIZE),
    .AW       (AW)
  ) u_load_counter (
    .clk  (clk),
    .reset(reset),
    .xfer (xfer),
    .clear(load_done),
    .idx  (imem_addr),
    .we   (imem_we),
    .ovf  (load_ovf)
  );

  assign imem_wdata = load_data;

  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    core_rst   = 1'b1;
    core_en    = 1'b0;
    halted     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (xfer && !load_last) state_d = ST_LOAD;
        else if (start)         state_d = ST_RUN;
      end
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_done) state_d = ST_IDLE;
      end
      ST_RUN: begin
        core_rst = 1'b0;
        core_en  = !halt_insn;
        if (halt_insn) state_d = ST_HALT;
`ifdef STEP_DEBUG_EN
        else if (pause) state_d = ST_PAUSE;
`endif
      end
`ifdef STEP_DEBUG_EN
      ST_PAUSE: begin
        core_rst = 1'b0;
        core_en  = step && !halt_insn;
        if (step && halt_insn) state_d = ST_HALT;
        else if (!pause)       state_d = ST_RUN;
      end
`endif
      ST_HALT: begin
        halted = 1'b1;
        if (start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cycle_count_d = cycle_count_q;
    if (state_q == ST_IDLE && state_d == ST_RUN) cycle_count_d = '0;
    else if (core_en)                            cycle_count_d = cycle_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_core_run_controller.sv
// Directed bench for core_run_controller (IMEM_SIZE=4); define STEP_DEBUG_EN
// on both bench and RTL to also exercise pause/step.
module tb_core_run_controller;

  localparam int IMEM_SIZE = 4;
  localparam int AW        = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ADDI   = 32'h0050_0093;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_last;
  logic          load_ready;
  logic          start;
`ifdef STEP_DEBUG_EN
  logic          pause;
  logic          step;
`endif
  logic [31:0]   instruction;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          core_en;
  logic          halted;
  logic          load_ovf;
  logic [31:0]   cycle_count;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  core_run_controller #(
    .IMEM_SIZE(IMEM_SIZE),
    .AW       (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .start      (start),
`ifdef STEP_DEBUG_EN
    .pause      (pause),
    .step       (step),
`endif
    .instruction(instruction),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .core_en    (core_en),
    .halted     (halted),
    .load_ovf   (load_ovf),
    .cycle_count(cycle_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one load beat, check the write port, then clock it in.
  task automatic load_beat(input logic [31:0] data, input logic last,
                           input logic exp_we, input logic [AW-1:0] exp_addr);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    #1;
    check("ld_ready", {31'd0, load_ready}, 32'd1);
    check("ld_we",    {31'd0, imem_we},    {31'd0, exp_we});
    if (exp_we) begin
      check("ld_addr",  {30'd0, imem_addr}, {30'd0, exp_addr});
      check("ld_wdata", imem_wdata,         data);
    end
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  logic [31:0] prog [3];
  logic [31:0] cnt_base;

  initial begin
    prog[0] = ADDI; prog[1] = EBREAK; prog[2] = NOP;
    reset = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    start = 1'b0; instruction = NOP;
`ifdef STEP_DEBUG_EN
    pause = 1'b0; step = 1'b0;
`endif
    #2;
    check("rst_core_rst", {31'd0, core_rst},   32'd1);
    check("rst_core_en",  {31'd0, core_en},    32'd0);
    check("rst_halted",   {31'd0, halted},     32'd0);
    check("rst_we",       {31'd0, imem_we},    32'd0);
    check("rst_ready",    {31'd0, load_ready}, 32'd1);
    check("rst_ovf",      {31'd0, load_ovf},   32'd0);
    check("rst_count",    cycle_count,         32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // Three-word program, last on the third word.
    for (int i = 0; i < 3; i++) load_beat(prog[i], i == 2, 1'b1, AW'(i));
    check("load3_ready", {31'd0, load_ready}, 32'd1);
    check("load3_rst",   {31'd0, core_rst},   32'd1);
    check("load3_ovf",   {31'd0, load_ovf},   32'd0);

    // Six-word stream into a four-word memory: last two beats dropped.
    for (int i = 0; i < 6; i++) load_beat(32'hA000_0000 + i, i == 5, i < 4, AW'(i));
    check("ovf_set",   {31'd0, load_ovf},   32'd1);
    check("ovf_ready", {31'd0, load_ready}, 32'd1);

    // Run: one useful instruction then EBREAK.
    start = 1'b1;
    tick();
    start = 1'b0;
    instruction = ADDI;
    #1;
    check("run_core_rst", {31'd0, core_rst}, 32'd0);
    check("run_en",       {31'd0, core_en},  32'd1);
    check("run_count0",   cycle_count,       32'd0);
    tick();
    instruction = EBREAK;
    #1;
    check("ebreak_en",     {31'd0, core_en}, 32'd0);
    check("ebreak_halted", {31'd0, halted},  32'd0);
    tick();
    check("halt_halted", {31'd0, halted},   32'd1);
    check("halt_count",  cycle_count,       32'd1);
    check("halt_rst",    {31'd0, core_rst}, 32'd1);
    check("halt_en",     {31'd0, core_en},  32'd0);
    load_valid = 1'b1;
    #1;
    check("halt_ready", {31'd0, load_ready}, 32'd0);
    check("halt_we",    {31'd0, imem_we},    32'd0);
    load_valid = 1'b0;

    // HALT -> IDLE -> RUN clears the counter.
    start = 1'b1;
    tick();
    start = 1'b0;
    instruction = NOP;
    #1;
    check("idle_rst",    {31'd0, core_rst},   32'd1);
    check("idle_halted", {31'd0, halted},     32'd0);
    check("idle_ready",  {31'd0, load_ready}, 32'd1);
    check("idle_count",  cycle_count,         32'd1);
    start = 1'b1;
    tick();
    check("rerun_count", cycle_count,       32'd0);
    check("rerun_rst",   {31'd0, core_rst}, 32'd0);
    // start is ignored while running.
    tick();
    start = 1'b0;
    check("run_start_ign", {31'd0, core_rst}, 32'd0);
    tick(); tick();
    check("run_count3", cycle_count, 32'd3);
    load_valid = 1'b1;
    #1;
    check("run_ready", {31'd0, load_ready}, 32'd0);
    check("run_we",    {31'd0, imem_we},    32'd0);
    load_valid = 1'b0;
    instruction = ECALL;
    #1;
    check("ecall_en", {31'd0, core_en}, 32'd0);
    instruction = NOP;

    // Asynchronous reset mid-run, no clock edge in between.
    #1;
    reset = 1'b1;
    #1;
    check("arst_core_rst", {31'd0, core_rst},   32'd1);
    check("arst_core_en",  {31'd0, core_en},    32'd0);
    check("arst_ready",    {31'd0, load_ready}, 32'd1);
    check("arst_count",    cycle_count,         32'd0);
    check("arst_ovf",      {31'd0, load_ovf},   32'd0);
    tick();
    reset = 1'b0;
    tick();

`ifdef STEP_DEBUG_EN
    start = 1'b1;
    tick();
    start = 1'b0;
    pause = 1'b1;
    #1;
    check("pre_pause_en", {31'd0, core_en}, 32'd1);
    tick();
    cnt_base = 32'd1;
    check("pause_count", cycle_count,       cnt_base);
    check("pause_en",    {31'd0, core_en},  32'd0);
    check("pause_rst",   {31'd0, core_rst}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      #1;
      check("step_en", {31'd0, core_en}, 32'd1);
      tick();
      step = 1'b0;
      tick();
    end
    check("step_count", cycle_count, cnt_base + 32'd3);
    pause = 1'b0;
    tick();
    check("resume_en", {31'd0, core_en}, 32'd1);
`else
    cnt_base = 32'd0;
    check("idle_after_rst", cycle_count, cnt_base);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/core_run_controller.md
CORE_RUN_CONTROLLER -- requirements
Module: core_run_controller

Interface
REQ-001 SHALL have parameter IMEM_SIZE, default 128, meaning instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter AW, default $clog2(IMEM_SIZE), meaning load word-index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load_valid  input  1  loader offers a program word.
REQ-006 SHALL have port load_data  input  32  program word.
REQ-007 SHALL have port load_last  input  1  current word is the final word of the program.
REQ-008 SHALL have port load_ready  output  1  controller accepts a word this cycle.
REQ-009 SHALL have port start  input  1  single-cycle pulse: begin run, or clear halt.
REQ-010 SHALL have port instruction  input  32  word currently fetched by the core.
REQ-011 SHALL have ports imem_we (output, 1), imem_addr (output, AW) and imem_wdata (output, 32), meaning the instruction-memory write port.
REQ-012 SHALL have port core_rst  output  1  holds the core's PC and register file in reset.
REQ-013 SHALL have port core_en  output  1  PC/register/data-memory write enable for the core.
REQ-014 SHALL have ports halted (output, 1), load_ovf (output, 1) and cycle_count (output, 32), meaning status and run counter.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD, RUN and HALT (plus PAUSE, see REQ-029).
REQ-016 load_ready SHALL be 1 in IDLE and LOAD, and 0 in all other states; a beat SHALL transfer when load_valid && load_ready.
REQ-017 On a transfer, imem_we=1, imem_addr=word index and imem_wdata=load_data SHALL be driven combinationally in the same cycle; the index SHALL increment on the following edge.
REQ-018 IDLE->LOAD SHALL occur on a transfer without load_last; LOAD->IDLE SHALL occur on a transfer with load_last; a transfer in IDLE with load_last SHALL stay in IDLE.
REQ-019 A transfer while index==IMEM_SIZE-1 SHALL be written; later transfers SHALL be accepted but dropped (imem_we=0), the index SHALL saturate and load_ovf SHALL be set sticky.
REQ-020 Entering IDLE from LOAD SHALL zero the word index.
REQ-021 IDLE+start SHALL go to RUN; core_rst SHALL be 1 in every state except RUN and PAUSE.
REQ-022 In RUN, core_en SHALL equal !halt_insn, where halt_insn = instruction is ECALL (32'h00000073) or EBREAK (32'h00100073); this is combinational so the PC does not pass the halt instruction.
REQ-023 RUN with halt_insn SHALL go to HALT on the next edge; halted SHALL be 1 only in HALT.
REQ-024 HALT+start SHALL go to IDLE; core_rst SHALL hold the core reset, and program memory SHALL be kept.
REQ-025 cycle_count SHALL increment on each edge where core_en=1, SHALL wrap at 2^32, and SHALL clear on IDLE->RUN.
REQ-026 start SHALL be ignored in LOAD, RUN and PAUSE; load_valid SHALL be ignored (not acknowledged) in RUN, HALT and PAUSE.

Reset
REQ-027 While reset=1 the block SHALL be in state IDLE with word index 0, cycle_count 0 and load_ovf 0, and SHALL drive core_rst 1, core_en 0, halted 0, imem_we 0 and load_ready 1.
REQ-028 Reset mid-LOAD or mid-RUN SHALL abort immediately; already-written imem words SHALL be left unchanged.

Configuration
REQ-029 With STEP_DEBUG_EN defined, inputs pause and step SHALL exist; RUN+pause SHALL go to PAUSE, where core_en = step && !halt_insn; PAUSE+step with halt_insn SHALL go to HALT; PAUSE with pause=0 SHALL go to RUN.
REQ-030 Without STEP_DEBUG_EN, the pause and step ports and the PAUSE state SHALL be absent, and behaviour SHALL be identical to REQ-015..026.

Structure
REQ-031 Package rv_ctrl_pkg SHALL hold the state enum typedef and the ECALL/EBREAK encodings.
REQ-032 Sub-module imem_load_counter SHALL implement the saturating index and overflow flag (REQ-019/020).

Verification
REQ-033 Scenario: load 3 words 0x00500093, 0x00100073, 0x00000013 (last on the third) -> imem writes at addr 0,1,2, then state IDLE with load_ovf=0.
REQ-034 Scenario: IMEM_SIZE=4, stream 6 words -> addr 0..3 written, words 5-6 dropped, load_ovf=1.
REQ-035 Scenario: start after program with EBREAK at word 1 -> core_en=1 for 1 cycle, core_en=0 while instruction=0x00100073, halted=1 next cycle, cycle_count=1.
REQ-036 Scenario: HALT then start -> IDLE with core_rst=1; start again -> cycle_count cleared to 0.
REQ-037 Scenario: assert reset during RUN -> core_rst=1, core_en=0 and state IDLE with no clock edge.
REQ-038 Scenario (STEP_DEBUG_EN): pause in RUN, three step pulses -> cycle_count advances exactly 3.
